// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the 32-bit datapath.
// Fetch (T0-T2), then an opcode-specific execute sequence (T3-T7), then back to T0.
module control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_SUB = 5'b00100,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        PC_out,
  output logic        Zlo_out,
  output logic        MDR_out,
  output logic        R_out,
  output logic        BAout,
  output logic        C_out,
  output logic        In_out,
  output logic        MAR_in,
  output logic        Zlo_in,
  output logic        PC_in,
  output logic        MDR_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Rin,
  output logic        Out_rd,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  op_sel,
  output logic        run,
  output logic        illegal
);

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_IN   = 5'b01011;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b01100;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    K_ALU, K_LDI, K_LD, K_ST, K_IN, K_OUT, K_NOP, K_HALT, K_ILL
  } kind_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  kind_e           kind_ir, kind_q;
  state_e          boundary_c;
  logic            unused_ir;

  // Instruction class of an opcode; anything unlisted is illegal.
  function automatic kind_e decode(input logic [OP_W-1:0] op);
    kind_e k;
    k = K_ILL;
    if (op == ALU_ADD || op == ALU_SUB || op == ALU_AND || op == ALU_OR) k = K_ALU;
    else if (op == OP_LDI)  k = K_LDI;
    else if (op == OP_LD)   k = K_LD;
    else if (op == OP_ST)   k = K_ST;
    else if (op == OP_IN)   k = K_IN;
    else if (op == OP_OUT)  k = K_OUT;
    else if (op == OP_NOP)  k = K_NOP;
    else if (op == OP_HALT) k = K_HALT;
    return k;
  endfunction

  assign kind_ir   = decode(ir[31:27]);
  assign kind_q    = decode(op_q);
  assign unused_ir = ^ir[26:0];

  // Instruction boundary: a pending stop diverts to HALT instead of the next fetch.
  assign boundary_c = stop ? S_HALT : S_T0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode is captured in T3 so T4-T7 sequencing does not depend on IR holding still.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        op_d = ir[31:27];
        case (kind_ir)
          K_ALU, K_LDI, K_LD, K_ST: state_d = S_T4;
          K_HALT:                   state_d = S_HALT;
          default:                  state_d = boundary_c;
        endcase
      end
      S_T4:  state_d = S_T5;
      S_T5:  state_d = (kind_q == K_LD || kind_q == K_ST) ? S_T6 : boundary_c;
      S_T6:  state_d = S_T7;
      S_T7:  state_d = boundary_c;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Control word decode; T3 reads the freshly loaded IR, later steps the captured opcode.
  always_comb begin
    PC_out  = 1'b0;
    Zlo_out = 1'b0;
    MDR_out = 1'b0;
    R_out   = 1'b0;
    BAout   = 1'b0;
    C_out   = 1'b0;
    In_out  = 1'b0;
    MAR_in  = 1'b0;
    Zlo_in  = 1'b0;
    PC_in   = 1'b0;
    MDR_in  = 1'b0;
    IR_in   = 1'b0;
    Y_in    = 1'b0;
    Rin     = 1'b0;
    Out_rd  = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    op_sel  = '0;
    illegal = 1'b0;
    run     = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Zlo_in = 1'b1;
      end
      S_T1: begin
        Zlo_out = 1'b1;
        PC_in   = 1'b1;
        Read    = 1'b1;
        MDR_in  = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
      end
      S_T3: begin
        case (kind_ir)
          K_ALU: begin
            Grb   = 1'b1;
            R_out = 1'b1;
            Y_in  = 1'b1;
          end
          K_LDI, K_LD, K_ST: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Y_in  = 1'b1;
          end
          K_IN: begin
            In_out = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end
          K_OUT: begin
            Gra    = 1'b1;
            R_out  = 1'b1;
            Out_rd = 1'b1;
          end
          K_ILL:   illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        Zlo_in = 1'b1;
        if (kind_q == K_ALU) begin
          Grc    = 1'b1;
          R_out  = 1'b1;
          op_sel = op_q;
        end else begin
          C_out  = 1'b1;
          op_sel = ALU_ADD;
        end
      end
      S_T5: begin
        Zlo_out = 1'b1;
        if (kind_q == K_LD || kind_q == K_ST) begin
          MAR_in = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        MDR_in = 1'b1;
        if (kind_q == K_ST) begin
          Gra   = 1'b1;
          R_out = 1'b1;
        end else begin
          Read = 1'b1;
        end
      end
      S_T7: begin
        if (kind_q == K_ST) begin
          Write = 1'b1;
        end else begin
          MDR_out = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed and random instruction streams
// compared cycle by cycle against a per-instruction control-word model.
module tb_control_unit;

  typedef struct packed {
    logic       pc_out;
    logic       zlo_out;
    logic       mdr_out;
    logic       r_out;
    logic       ba_out;
    logic       c_out;
    logic       in_out;
    logic       mar_in;
    logic       zlo_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       rin;
    logic       out_rd;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       run;
    logic       illegal;
    logic [4:0] op_sel;
  } cw_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_IN   = 5'b01011;
  localparam logic [4:0] OP_OUT  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic        clk = 1'b0;
  logic        clr;
  logic        stop;
  logic [31:0] ir;
  logic PC_out, Zlo_out, MDR_out, R_out, BAout, C_out, In_out;
  logic MAR_in, Zlo_in, PC_in, MDR_in, IR_in, Y_in, Rin, Out_rd;
  logic Gra, Grb, Grc, IncPC, Read, Write, run, illegal;
  logic [4:0] op_sel;
  cw_t obs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
    .PC_out(PC_out), .Zlo_out(Zlo_out), .MDR_out(MDR_out), .R_out(R_out),
    .BAout(BAout), .C_out(C_out), .In_out(In_out),
    .MAR_in(MAR_in), .Zlo_in(Zlo_in), .PC_in(PC_in), .MDR_in(MDR_in),
    .IR_in(IR_in), .Y_in(Y_in), .Rin(Rin), .Out_rd(Out_rd),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .op_sel(op_sel), .run(run), .illegal(illegal)
  );

  assign obs = {PC_out, Zlo_out, MDR_out, R_out, BAout, C_out, In_out,
                MAR_in, Zlo_in, PC_in, MDR_in, IR_in, Y_in, Rin, Out_rd,
                Gra, Grb, Grc, IncPC, Read, Write, run, illegal, op_sel};

  function automatic bit is_alu(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Total cycles of an instruction, fetch included.
  function automatic int instr_len(input logic [4:0] op);
    if (is_alu(op) || op == OP_LDI) return 6;
    if (op == OP_LD || op == OP_ST) return 8;
    return 4;
  endfunction

  // Expected control word in cycle k (0 = T0) of the instruction with opcode op.
  function automatic cw_t model_cw(input logic [4:0] op, input int k);
    cw_t c;
    int  e;
    c     = '0;
    c.run = 1'b1;
    e     = k - 3;
    if (k == 0) begin
      c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlo_in = 1'b1;
    end else if (k == 1) begin
      c.zlo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
    end else if (k == 2) begin
      c.mdr_out = 1'b1; c.ir_in = 1'b1;
    end else if (is_alu(op)) begin
      if (e == 0) begin
        c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
      end else if (e == 1) begin
        c.grc = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; c.op_sel = op;
      end else begin
        c.zlo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
      end
    end else if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
      if (e == 0) begin
        c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
      end else if (e == 1) begin
        c.c_out = 1'b1; c.zlo_in = 1'b1; c.op_sel = OP_ADD;
      end else if (e == 2 && op == OP_LDI) begin
        c.zlo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
      end else if (e == 2) begin
        c.zlo_out = 1'b1; c.mar_in = 1'b1;
      end else if (e == 3 && op == OP_LD) begin
        c.read = 1'b1; c.mdr_in = 1'b1;
      end else if (e == 3) begin
        c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
      end else if (op == OP_LD) begin
        c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
      end else begin
        c.write = 1'b1;
      end
    end else if (op == OP_IN) begin
      c.in_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
    end else if (op == OP_OUT) begin
      c.gra = 1'b1; c.r_out = 1'b1; c.out_rd = 1'b1;
    end else if (op != OP_NOP && op != OP_HALT) begin
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  task automatic check(input string tag, input cw_t exp);
    int drivers;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%07h expected=%07h", tag, obs, exp);
    end
    drivers = $countones({obs.pc_out, obs.zlo_out, obs.mdr_out, obs.r_out,
                          obs.ba_out, obs.c_out, obs.in_out});
    n_cmp++;
    assert (drivers <= 1 && !(obs.read && obs.write)) else begin
      n_bad++;
      $error("FAIL %s excl: observed drivers=%0d rd=%b wr=%b expected <=1 and not both",
             tag, drivers, obs.read, obs.write);
    end
  endtask

  // Runs one instruction from T0; stop rises in cycle stop_at, upto truncates the run.
  task automatic do_instr(input string tag, input logic [31:0] iw,
                          input int stop_at, input int upto);
    int n;
    n = instr_len(iw[31:27]);
    if (upto >= 0 && upto < n) n = upto;
    ir = iw;
    for (int k = 0; k < n; k++) begin
      if (stop_at >= 0 && k >= stop_at) stop = 1'b1;
      #1;
      check($sformatf("%s k%0d", tag, k), model_cw(iw[31:27], k));
      @(negedge clk);
    end
  endtask

  task automatic halt_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      check($sformatf("%s h%0d", tag, i), '0);
      @(negedge clk);
    end
  endtask

  // Asserts clr asynchronously, releases it, and returns at the negedge inside T0.
  task automatic do_reset(input string tag);
    clr  = 1'b0;
    stop = 1'b0;
    #1;
    check({tag, " async"}, '0);
    @(negedge clk);
    #1;
    check({tag, " held"}, '0);
    clr = 1'b1;
    #1;
    check({tag, " released"}, '0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] riw;
    clr  = 1'b1;
    stop = 1'b0;
    ir   = '0;
    #2;
    do_reset("por");

    do_instr("add",  32'h1A300000, -1, -1);
    do_instr("ld",   32'h00800005, -1, -1);
    do_instr("st",   {OP_ST,  27'h0450003}, -1, -1);
    do_instr("ill",  32'hF8000000, -1, -1);
    do_instr("out",  {OP_OUT, 27'h0800000}, -1, -1);
    do_instr("in",   {OP_IN,  27'h1000000}, -1, -1);
    do_instr("ldi",  {OP_LDI, 27'h0880010}, -1, -1);
    do_instr("sub",  {OP_SUB, 27'h0123000}, -1, -1);
    do_instr("and",  {OP_AND, 27'h0456000}, -1, -1);
    do_instr("or",   {OP_OR,  27'h0789000}, -1, -1);

    for (int i = 0; i < 10; i++) do_instr($sformatf("nop%0d", i), {OP_NOP, 27'd0}, -1, -1);

    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == OP_HALT) rop = OP_NOP;
      riw = {rop, 27'($urandom)};
      do_instr($sformatf("rnd%0d op%02h", i, rop), riw, -1, -1);
    end

    do_instr("add_pre_rst", 32'h1A300000, -1, 4);
    do_reset("mid_t4");
    do_instr("add_post_rst", 32'h1A300000, -1, -1);

    do_instr("sub_stop", {OP_SUB, 27'h0234000}, 1, -1);
    halt_check("stop_halt", 5);

    do_reset("unhalt");
    do_instr("halt", {OP_HALT, 27'd0}, -1, -1);
    halt_check("halted", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
